pipe_ripple_borrow_subtractor: RTL and testbench

//  Pipelined ripple-borrow subtractor: diff = A - B - bin, with bout as the final borrow.
//  It is the inverse-direction companion of the pipelined ripple-carry adder and shares its operand widths and CLK/RESETn scheme.
//  The borrow chain is cut into STAGES register slices.

---
 rtl/dld_arith_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/pipe_ripple_borrow_subtractor.sv | 150 +++++++++++++++
 tb/tb_pipe_ripple_borrow_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dld_arith_pkg.sv
// Shared arithmetic defaults for the pipelined ripple adder/subtractor family.
// Holds operand/pipeline sizing and the configuration legality check.
package dld_arith_pkg;

    localparam int unsigned DEF_BW     = 32;
    localparam int unsigned DEF_STAGES = 4;

    function automatic int unsigned slice_width(input int unsigned bw, input int unsigned stages);
        return (stages == 0) ? 0 : bw / stages;
    endfunction

    // Legal only when every stage gets an equal, non-empty slice.
    function automatic bit cfg_ok(input int unsigned bw, input int unsigned stages);
        return (stages != 0) && (bw >= stages) && ((bw % stages) == 0);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, bo set when the bit underflows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/pipe_ripple_borrow_subtractor.sv
// Pipelined ripple-borrow subtractor: diff = A - B - bin, bout = final borrow.
// Borrow chain cut into STAGES slices with operand skew and result deskew.
module pipe_ripple_borrow_subtractor
    import dld_arith_pkg::*;
#(
    parameter int unsigned BW     = DEF_BW,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          en,
    input  logic          valid_in,
    input  logic [BW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic          bin,
    output logic [BW-1:0] diff,
    output logic          bout,
    output logic          valid_out
);

    localparam int unsigned SW = slice_width(BW, STAGES);

    if (!cfg_ok(BW, STAGES)) begin : g_cfg_err
        $error("pipe_ripple_borrow_subtractor: BW must be a multiple of STAGES");
    end

    // stage_bo[k] is the borrow entering stage k; stage_bo[STAGES] is bout.
    logic [STAGES:0]   stage_bo;
    logic [STAGES-1:0] valid_q, valid_d;

    assign stage_bo[0] = bin;
    assign bout        = stage_bo[STAGES];
    assign valid_out   = valid_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        if (en) begin
            valid_d = (valid_q << 1) | STAGES'(valid_in);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned DSK = STAGES - 1 - k;

        logic [SW-1:0] a_stg, b_stg, d_comb;
        logic [SW-1:0] slice_q, slice_d;
        logic          borrow_q, borrow_d;

        if (k == 0) begin : g_no_skew
            assign a_stg = A[SW-1:0];
            assign b_stg = B[SW-1:0];
        end else begin : g_skew
            localparam int unsigned KW = k * SW;
            logic [KW-1:0] a_skew_q, a_skew_d, b_skew_q, b_skew_d;

            // Newest slice enters at the bottom; the top slot is k edges old.
            always_comb begin
                a_skew_d = a_skew_q;
                b_skew_d = b_skew_q;
                if (en) begin
                    a_skew_d = (a_skew_q << SW) | KW'(A[k*SW +: SW]);
                    b_skew_d = (b_skew_q << SW) | KW'(B[k*SW +: SW]);
                end
            end

            always_ff @(posedge CLK) begin
                if (!RESETn) begin
                    a_skew_q <= '0;
                    b_skew_q <= '0;
                end else begin
                    a_skew_q <= a_skew_d;
                    b_skew_q <= b_skew_d;
                end
            end

            assign a_stg = a_skew_q[KW-1 -: SW];
            assign b_stg = b_skew_q[KW-1 -: SW];
        end

        for (genvar i = 0; i < SW; i++) begin : g_bit
            logic bi_w, bo_w;
            if (i == 0) begin : g_first
                assign bi_w = stage_bo[k];
            end else begin : g_next
                assign bi_w = g_bit[i-1].bo_w;
            end
            full_subtractor u_fs (
                .a  (a_stg[i]),
                .b  (b_stg[i]),
                .bi (bi_w),
                .d  (d_comb[i]),
                .bo (bo_w)
            );
        end

        always_comb begin
            slice_d  = slice_q;
            borrow_d = borrow_q;
            if (en) begin
                slice_d  = d_comb;
                borrow_d = g_bit[SW-1].bo_w;
            end
        end

        always_ff @(posedge CLK) begin
            if (!RESETn) begin
                slice_q  <= '0;
                borrow_q <= '0;
            end else begin
                slice_q  <= slice_d;
                borrow_q <= borrow_d;
            end
        end

        assign stage_bo[k+1] = borrow_q;

        if (DSK == 0) begin : g_no_deskew
            assign diff[k*SW +: SW] = slice_q;
        end else begin : g_deskew
            localparam int unsigned DW = DSK * SW;
            logic [DW-1:0] dsk_q, dsk_d;

            always_comb begin
                dsk_d = dsk_q;
                if (en) begin
                    dsk_d = (dsk_q << SW) | DW'(slice_q);
                end
            end

            always_ff @(posedge CLK) begin
                if (!RESETn) begin
                    dsk_q <= '0;
                end else begin
                    dsk_q <= dsk_d;
                end
            end

            assign diff[k*SW +: SW] = dsk_q[DW-1 -: SW];
        end
    end

endmodule

// File: tb/tb_pipe_ripple_borrow_subtractor.sv
// Scoreboard bench for pipe_ripple_borrow_subtractor at STAGES = 4, 1 and 32,
// all driven by the same directed stimulus.
module tb_pipe_ripple_borrow_subtractor;

    localparam int unsigned BW = 32;
    localparam int unsigned NI = 3;

    function automatic int unsigned st_of(input int unsigned idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    typedef struct {
        logic [BW-1:0] d;
        logic          bo;
        int unsigned   tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          RESETn = 1'b0;
    logic          en = 1'b0;
    logic          valid_in = 1'b0;
    logic [BW-1:0] A = '0;
    logic [BW-1:0] B = '0;
    logic          bin = 1'b0;

    logic [BW-1:0] diff_w [NI];
    logic          bout_w [NI];
    logic          vout_w [NI];

    exp_t        exp_q [NI][$];
    int unsigned en_edges = 0;
    int          total = 0;
    int          bad = 0;
    bit          stim_done = 1'b0;

    always #10 clk = ~clk;

    // Edges at which the pipeline registers may change (advance or reset).
    always @(posedge clk) begin
        if (en || !RESETn) en_edges <= en_edges + 1;
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipe_ripple_borrow_subtractor #(
            .BW     (BW),
            .STAGES (st_of(g))
        ) dut (
            .CLK       (clk),
            .RESETn    (RESETn),
            .en        (en),
            .valid_in  (valid_in),
            .A         (A),
            .B         (B),
            .bin       (bin),
            .diff      (diff_w[g]),
            .bout      (bout_w[g]),
            .valid_out (vout_w[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all(input logic [BW-1:0] d, input logic bo);
        exp_t e;
        e.d   = d;
        e.bo  = bo;
        e.tag = en_edges;
        for (int unsigned i = 0; i < NI; i++) exp_q[i].push_back(e);
    endtask

    task automatic op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic bi,
                      input logic [BW-1:0] d, input logic bo);
        en = 1'b1; valid_in = 1'b1; A = a; B = b; bin = bi;
        push_all(d, bo);
        step();
    endtask

    task automatic model_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic bi);
        logic [BW:0] r;
        r = {1'b0, a} - {1'b0, b} - {{BW{1'b0}}, bi};
        op(a, b, bi, r[BW-1:0], r[BW]);
    endtask

    task automatic bubble();
        en = 1'b1; valid_in = 1'b0;
        A = $urandom; B = $urandom; bin = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic stall_cycle();
        en = 1'b0; valid_in = 1'b1;
        A = $urandom; B = $urandom; bin = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic flush_queues();
        for (int unsigned i = 0; i < NI; i++) exp_q[i].delete();
    endtask

    function automatic bit queues_empty();
        for (int unsigned i = 0; i < NI; i++) if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic monitor();
        int unsigned   seen = 0;
        bit            adv;
        logic [BW+1:0] prev [NI];
        logic [BW+1:0] cur;
        exp_t          e;
        while (!stim_done) begin
            @(negedge clk);
            adv  = (en_edges != seen);
            seen = en_edges;
            for (int unsigned i = 0; i < NI; i++) begin
                cur = {vout_w[i], bout_w[i], diff_w[i]};
                if (!adv) begin
                    check($sformatf("frozen_S%0d", st_of(i)), 64'(cur), 64'(prev[i]));
                end else if (vout_w[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_valid_S%0d", st_of(i)), 64'(vout_w[i]), 64'(0));
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("diff_S%0d", st_of(i)), 64'(diff_w[i]), 64'(e.d));
                        check($sformatf("bout_S%0d", st_of(i)), 64'(bout_w[i]), 64'(e.bo));
                        check($sformatf("latency_S%0d", st_of(i)), 64'(en_edges - e.tag), 64'(st_of(i)));
                    end
                end else if (exp_q[i].size() != 0 && (en_edges - exp_q[i][0].tag) >= st_of(i)) begin
                    check($sformatf("missing_valid_S%0d", st_of(i)), 64'(vout_w[i]), 64'(1));
                    void'(exp_q[i].pop_front());
                end
                prev[i] = cur;
            end
        end
    endtask

    task automatic run_stimulus();
        logic [BW-1:0] a, b;

        // Reset with live-looking inputs; nothing may be accepted.
        RESETn = 1'b0;
        for (int n = 0; n < 3; n++) begin
            en = 1'b1; valid_in = 1'b1; A = $urandom; B = $urandom; bin = 1'($urandom_range(0, 1));
            step();
        end
        for (int unsigned i = 0; i < NI; i++) begin
            check($sformatf("reset_diff_S%0d", st_of(i)), 64'(diff_w[i]), 64'(0));
            check($sformatf("reset_bout_S%0d", st_of(i)), 64'(bout_w[i]), 64'(0));
            check($sformatf("reset_valid_S%0d", st_of(i)), 64'(vout_w[i]), 64'(0));
        end
        RESETn = 1'b1;
        op(32'd5, 32'd3, 1'b0, 32'd2, 1'b0);

        // Directed boundaries and full-width borrow ripple.
        op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0);
        op(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0);
        op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1);
        op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
        op(32'h1000_0000, 32'h0000_0000, 1'b1, 32'h0FFF_FFFF, 1'b0);
        op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0);
        bubble();

        // Streaming, back to back.
        a = 32'hFFFF_0000;
        b = 32'h0000_8000;
        for (int n = 0; n < 200; n++) begin
            model_op(a, b, 1'($urandom_range(0, 1)));
            a = a + 32'd30000;
            b = b + 32'd50000;
        end

        // Stall with four ops in flight; stalled inputs must be ignored.
        op(32'd100, 32'd1, 1'b0, 32'd99, 1'b0);
        op(32'd7, 32'd9, 1'b0, 32'hFFFF_FFFE, 1'b1);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        op(32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000E, 1'b0);
        for (int n = 0; n < 5; n++) stall_cycle();
        for (int n = 0; n < 6; n++) bubble();

        // Alternating bubbles, then a reset with ops still in flight.
        op(32'd50, 32'd20, 1'b0, 32'd30, 1'b0);
        bubble();
        op(32'd20, 32'd50, 1'b0, 32'hFFFF_FFE2, 1'b1);
        bubble();
        op(32'hABCD_0000, 32'h0000_0001, 1'b1, 32'hABCC_FFFE, 1'b0);
        bubble();
        op(32'd1, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        op(32'd9, 32'd4, 1'b0, 32'd5, 1'b0);
        bubble();
        op(32'd3, 32'd4, 1'b0, 32'hFFFF_FFFF, 1'b1);
        RESETn = 1'b0; en = 1'b0; valid_in = 1'b1;
        step();
        flush_queues();
        RESETn = 1'b1;
        for (int n = 0; n < 3; n++) bubble();
        op(32'd1000, 32'd1, 1'b0, 32'd999, 1'b0);

        // Drain, bounded.
        for (int n = 0; n < 100 && !queues_empty(); n++) bubble();
        for (int unsigned i = 0; i < NI; i++)
            check($sformatf("drain_S%0d", st_of(i)), 64'(exp_q[i].size()), 64'(0));
        for (int n = 0; n < 3; n++) bubble();
        stim_done = 1'b1;
    endtask

    initial begin
        fork
            run_stimulus();
            monitor();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
